// File: rtl/synaptic_event_accumulator.sv
// Synaptic event accumulator: queues presynaptic spike indices, looks up their weights,
// sums them with saturation and commits the result as i_syn once per neuron tick (clk_en).
// Optional feature: define SYN_EVCNT_EN to add ev_cnt_o, the count of weights integrated
// in the committed tick (saturating at 255).
module synaptic_event_accumulator #(
  parameter int unsigned WEIGHT_W   = 16,
  parameter int unsigned N_PRE      = 64,
  parameter int unsigned IDX_W      = $clog2(N_PRE),
  parameter int unsigned ACC_W      = 20,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                ev_valid,
  output logic                ev_ready,
  input  logic [IDX_W-1:0]    ev_idx,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_addr,
  input  logic [WEIGHT_W-1:0] wr_data,
  output logic [WEIGHT_W-1:0] i_syn,
  output logic                sat_o
`ifdef SYN_EVCNT_EN
  ,
  output logic [7:0]          ev_cnt_o
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  // Event FIFO; pointers carry one extra wrap bit to tell full from empty.
  logic [IDX_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PtrW:0]    wptr_q, rptr_q;
  logic             fifo_full, fifo_empty, push, pop;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                      (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign ev_ready   = !fifo_full;
  assign push       = ev_valid && !fifo_full;
  // Single-port weight RAM: a write steals the port, so the pop waits.
  assign pop        = !fifo_empty && !wr_en;

  // FIFO storage (not reset; validity is tracked by the pointers).
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q[PtrW-1:0]] <= ev_idx;
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + {{PtrW{1'b0}}, 1'b1};
      if (pop)  rptr_q <= rptr_q + {{PtrW{1'b0}}, 1'b1};
    end
  end

  // Weight RAM with registered read driven by the FIFO head on pop.
  logic [WEIGHT_W-1:0] weight_mem [N_PRE];
  logic [WEIGHT_W-1:0] s2_w_q;
  logic                s2_valid_q;

  always_ff @(posedge clk) begin
    if (wr_en) weight_mem[wr_addr] <= wr_data;
    if (pop)   s2_w_q <= weight_mem[fifo_mem[rptr_q[PtrW-1:0]]];
  end

  // Read-valid stage; cleared by reset so in-flight reads are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_valid_q <= 1'b0;
    else        s2_valid_q <= pop;
  end

  // Saturating accumulate and clamp to the output width.
  logic [ACC_W-1:0]    acc_q, acc_next;
  logic [ACC_W:0]      sum_ext;
  logic [ACC_W-WEIGHT_W:0] acc_upper;
  logic                acc_sat, out_sat, sticky_q;
  logic [WEIGHT_W-1:0] i_syn_next, i_syn_q;
  logic                sat_q;

  always_comb begin
    acc_next   = acc_q;
    acc_sat    = 1'b0;
    sum_ext    = {acc_q[ACC_W-1], acc_q} +
                 {{(ACC_W + 1 - WEIGHT_W){s2_w_q[WEIGHT_W-1]}}, s2_w_q};
    if (s2_valid_q) begin
      // Overflow iff the two top bits of the extended sum disagree.
      if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
        acc_sat  = 1'b1;
        acc_next = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_next = sum_ext[ACC_W-1:0];
      end
    end
    // Value fits WEIGHT_W iff all bits from the WEIGHT_W sign bit upward agree.
    acc_upper  = acc_next[ACC_W-1:WEIGHT_W-1];
    out_sat    = !((&acc_upper) || !(|acc_upper));
    if (out_sat) begin
      i_syn_next = acc_next[ACC_W-1] ? {1'b1, {(WEIGHT_W-1){1'b0}}}
                                     : {1'b0, {(WEIGHT_W-1){1'b1}}};
    end else begin
      i_syn_next = acc_next[WEIGHT_W-1:0];
    end
  end

  // Tick commit: publish the clamped sum, restart accumulation for the next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
      i_syn_q  <= '0;
      sat_q    <= 1'b0;
    end else if (clk_en) begin
      i_syn_q  <= i_syn_next;
      sat_q    <= sticky_q | acc_sat | out_sat;
      acc_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      acc_q    <= acc_next;
      sticky_q <= sticky_q | acc_sat;
    end
  end

  assign i_syn = i_syn_q;
  assign sat_o = sat_q;

`ifdef SYN_EVCNT_EN
  logic [7:0] cnt_q, cnt_next, ev_cnt_q;

  always_comb begin
    cnt_next = cnt_q;
    if (s2_valid_q && (cnt_q != 8'hFF)) cnt_next = cnt_q + 8'd1;
  end

  // Per-tick integrated-weight counter, committed alongside i_syn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      ev_cnt_q <= '0;
    end else if (clk_en) begin
      ev_cnt_q <= cnt_next;
      cnt_q    <= '0;
    end else begin
      cnt_q    <= cnt_next;
    end
  end

  assign ev_cnt_o = ev_cnt_q;
`endif

endmodule

// File: tb/tb_synaptic_event_accumulator.sv
// Directed self-checking bench for synaptic_event_accumulator.
module tb_synaptic_event_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic [5:0]  ev_idx = '0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic signed [15:0] i_syn;
  logic        sat_o;
`ifdef SYN_EVCNT_EN
  logic [7:0]  ev_cnt_o;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int accepts;

  always #5 clk = ~clk;

  synaptic_event_accumulator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_idx   (ev_idx),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .i_syn    (i_syn),
    .sat_o    (sat_o)
`ifdef SYN_EVCNT_EN
    ,
    .ev_cnt_o (ev_cnt_o)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic ev(input logic [5:0] idx);
    ev_valid = 1'b1; ev_idx = idx;
    cyc();
    ev_valid = 1'b0;
  endtask

  task automatic tick();
    clk_en = 1'b1;
    cyc();
    clk_en = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_i_syn", i_syn, 0);
    check("reset_sat", sat_o, 0);
    check("reset_ev_ready", ev_ready, 1);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Basic sum: 100 + 100 - 40
    wr(6'd3, 16'sd100);
    wr(6'd5, -16'sd40);
    ev(6'd3); ev(6'd3); ev(6'd5);
    idle(4);
    check("basic_hold_before_tick", i_syn, 0);
    tick();
    check("basic_i_syn", i_syn, 160);
    check("basic_sat", sat_o, 0);

    // Saturation: 40 * 32767 overflows the accumulator
    wr(6'd0, 16'sd32767);
    ev_valid = 1'b1; ev_idx = 6'd0;
    idle(40);
    ev_valid = 1'b0;
    idle(4);
    check("sat_hold_i_syn", i_syn, 160);
    tick();
    check("sat_i_syn", i_syn, 32767);
    check("sat_flag", sat_o, 1);
    tick();
    check("sat_empty_i_syn", i_syn, 0);
    check("sat_empty_flag", sat_o, 0);

    // Backpressure: writes stall pops, FIFO fills at 8
    wr(6'd10, 16'sd1);
    wr(6'd11, 16'sd10);
    wr(6'd12, 16'sd100);
    wr(6'd13, 16'sd1000);
    accepts = 0;
    for (int i = 0; i < 12; i++) begin
      wr_en = 1'b1; wr_addr = 6'd20; wr_data = 16'sd5;
      ev_valid = 1'b1; ev_idx = 6'(10 + (i % 4));
      if (ev_ready) accepts++;
      cyc();
    end
    check("bp_ready_low", ev_ready, 0);
    check("bp_accepts", accepts, 8);
    wr_en = 1'b0; ev_valid = 1'b0;
    idle(12);
    check("bp_ready_after_drain", ev_ready, 1);
    tick();
    check("bp_sum", i_syn, 2222);

    // Tick boundary: first event counts in this tick, second in the next
    ev_valid = 1'b1; ev_idx = 6'd3;
    cyc();
    ev_idx = 6'd5;
    cyc();
    ev_valid = 1'b0;
    tick();
    check("boundary_first_tick", i_syn, 100);
    idle(4);
    tick();
    check("boundary_next_tick", i_syn, -40);
    check("boundary_sat", sat_o, 0);

    // Reset mid-operation: 5 queued events are discarded
    wr_en = 1'b1; wr_addr = 6'd20; wr_data = 16'sd5;
    ev_valid = 1'b1; ev_idx = 6'd3;
    idle(5);
    ev_valid = 1'b0; wr_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_async_i_syn", i_syn, 0);
    check("rst_ready", ev_ready, 1);
    cyc();
    rst_n = 1'b1;
    idle(6);
    tick();
    check("rst_next_tick", i_syn, 0);
    check("rst_next_sat", sat_o, 0);

    // 300 events in one tick, then 3 events
    ev_valid = 1'b1; ev_idx = 6'd3;
    idle(300);
    ev_valid = 1'b0;
    idle(4);
    tick();
    check("many_i_syn", i_syn, 30000);
`ifdef SYN_EVCNT_EN
    check("evcnt_sat", ev_cnt_o, 255);
`endif
    ev(6'd3); ev(6'd5); ev(6'd5);
    idle(4);
    tick();
    check("three_i_syn", i_syn, 20);
`ifdef SYN_EVCNT_EN
    check("evcnt_three", ev_cnt_o, 3);
`endif

    // clk_en held high: every cycle commits
    clk_en = 1'b1;
    ev_valid = 1'b1; ev_idx = 6'd3;
    cyc();
    ev_valid = 1'b0;
    cyc();
    check("cont_tick_before", i_syn, 0);
    cyc();
    check("cont_tick_event", i_syn, 100);
    cyc();
    check("cont_tick_after", i_syn, 0);
    clk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
